not_stim_checker: RTL and testbench

Self-checking stimulus stage for the inverter exercise. It sweeps every input vector into an inverter under test and samples the inverter's response. It compares each response against the bitwise complement of the stimulus and reports an error count, the first failing vector and a pass flag. It drives the gate's input and consumes its output, replacing hand-written `initial` sequences with a clocked, repeatable sweep.

---
 rtl/not_stim_checker.sv | 123 ++++++++++++
 tb/tb_not_stim_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/not_stim_checker.sv
`default_nettype none
// ============================================================================
//  Module      : not_stim_checker
//  Description : Clocked stimulus sweep and response checker for an inverter
//                under test. Optional macro NOT_STIM_STOP_ON_ERROR_EN ends the
//                sweep at the first mismatching vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module not_stim_checker #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_cnt,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_STIM_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   c_CNT_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] c_LAST     = '1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_stim;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [WIDTH:0]     r_err_cnt;
    logic               r_fail_seen;
    logic [WIDTH-1:0]   r_first_fail;

    logic               w_mismatch;
    logic               w_last;
    logic               w_stop;

    assign w_mismatch = (resp != ~r_stim);
    assign w_last     = (r_stim == c_LAST);

`ifdef NOT_STIM_STOP_ON_ERROR_EN
    assign w_stop = w_last || w_mismatch;
`else
    assign w_stop = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_DRIVE;
                        r_stim       <= '0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= '0;
                        r_fail_seen  <= 1'b0;
                        r_first_fail <= '0;
                    end
                end
                ST_DRIVE: begin
                    r_state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_err_cnt <= r_err_cnt + c_CNT_ONE;
                        if (!r_fail_seen) begin
                            r_first_fail <= r_stim;
                            r_fail_seen  <= 1'b1;
                        end
                    end
                    if (w_stop) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_stim  <= r_stim + c_STIM_ONE;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    // err_cnt already holds the final compare at this point
                    r_pass  <= (r_err_cnt == '0);
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim       = r_stim;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_seen  = r_fail_seen;
    assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_not_stim_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_not_stim_checker
//  Description : Directed bench for not_stim_checker at WIDTH 1, 2 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_not_stim_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // WIDTH=1 instance, inverter model selectable
    int         mode1 = 0;
    logic       start1 = 1'b0;
    logic       resp1;
    logic       stim1, busy1, done1, pass1, fs1, ff1;
    logic [1:0] err1;

    always_comb begin
        resp1 = ~stim1;
        case (mode1)
            1:       resp1 = stim1;
            2:       resp1 = 1'b1;
            default: resp1 = ~stim1;
        endcase
    end

    not_stim_checker #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .resp(resp1), .stim(stim1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_seen(fs1), .first_fail(ff1)
    );

    // WIDTH=2 instance, vector 2 answered wrongly
    logic       start2 = 1'b0;
    logic [1:0] resp2, stim2, ff2;
    logic       busy2, done2, pass2, fs2;
    logic [2:0] err2;

    assign resp2 = (stim2 == 2'd2) ? stim2 : ~stim2;

    not_stim_checker #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .resp(resp2), .stim(stim2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_seen(fs2), .first_fail(ff2)
    );

    // WIDTH=4 instance, correct inverter
    logic       start4 = 1'b0;
    logic [3:0] resp4, stim4, ff4;
    logic       busy4, done4, pass4, fs4;
    logic [4:0] err4;

    assign resp4 = ~stim4;

    not_stim_checker #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .resp(resp4), .stim(stim4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
        .fail_seen(fs4), .first_fail(ff4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic run1(input int mode, input int done_e, input int exp_err,
                        input int exp_ff, input int exp_pass);
        mode1 = mode;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check_eq("w1 stim at start", stim1, 0);
        check_eq("w1 busy at start", busy1, 1);
        for (int e = 1; e <= done_e + 1; e++) begin
            @(posedge clk);
            #1;
            if (e < done_e) begin
                check_eq("w1 stim seq", stim1, e / 2);
                check_eq("w1 done early", done1, 0);
            end else if (e == done_e) begin
                check_eq("w1 done pulse", done1, 1);
                check_eq("w1 stim held", stim1, done_e / 2 - 1);
                check_eq("w1 err_cnt at done", err1, exp_err);
            end else begin
                check_eq("w1 done low", done1, 0);
                check_eq("w1 busy low", busy1, 0);
                check_eq("w1 pass", pass1, exp_pass);
                check_eq("w1 err_cnt", err1, exp_err);
                check_eq("w1 fail_seen", fs1, (exp_err != 0) ? 1 : 0);
                if (exp_err != 0) check_eq("w1 first_fail", ff1, exp_ff);
            end
        end
    endtask

    task automatic run4(input bit repulse, input int abort_e);
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        check_eq("w4 stim at start", stim4, 0);
        for (int e = 1; e <= 33; e++) begin
            @(posedge clk);
            #1;
            start4 = 1'b0;
            if (e < 32) begin
                check_eq("w4 stim seq", stim4, e / 2);
                check_eq("w4 done early", done4, 0);
                check_eq("w4 busy", busy4, 1);
            end else if (e == 32) begin
                check_eq("w4 done pulse", done4, 1);
                check_eq("w4 stim held", stim4, 15);
            end else begin
                check_eq("w4 done low", done4, 0);
                check_eq("w4 busy low", busy4, 0);
                check_eq("w4 pass", pass4, 1);
                check_eq("w4 err_cnt", err4, 0);
                check_eq("w4 fail_seen", fs4, 0);
            end
            if (repulse && e == 9) start4 = 1'b1;
            if (abort_e == e) begin
                #4;
                rst_n = 1'b0;
                #1;
                check_eq("abort stim", stim4, 0);
                check_eq("abort busy", busy4, 0);
                check_eq("abort done", done4, 0);
                check_eq("abort pass", pass4, 0);
                check_eq("abort err_cnt", err4, 0);
                check_eq("abort fail_seen", fs4, 0);
                check_eq("abort first_fail", ff4, 0);
                return;
            end
        end
    endtask

    initial begin
        int exp_done2;
        int exp_stim2;
        int seen;

        #1 rst_n = 1'b0;
        #2;
        check_eq("reset stim1", stim1, 0);
        check_eq("reset busy1", busy1, 0);
        check_eq("reset done1", done1, 0);
        check_eq("reset pass1", pass1, 0);
        check_eq("reset err1", err1, 0);
        check_eq("reset fs1", fs1, 0);
        check_eq("reset ff4", ff4, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // correct inverter, faulty buffer, stuck-at-1, back-to-back starts
        run1(0, 4, 0, 0, 1);
`ifdef NOT_STIM_STOP_ON_ERROR_EN
        run1(1, 2, 1, 0, 0);
`else
        run1(1, 4, 2, 0, 0);
`endif
        run1(2, 4, 1, 1, 0);
        run1(0, 4, 0, 0, 1);

        run4(1'b1, 0);

        run4(1'b0, 9);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst_n = 1'b1;
            if (done4) check_eq("no done after abort", done4, 0);
        end
        check_eq("idle after abort", busy4, 0);
        run4(1'b0, 0);

`ifdef NOT_STIM_STOP_ON_ERROR_EN
        exp_done2 = 6;
        exp_stim2 = 2;
`else
        exp_done2 = 8;
        exp_stim2 = 3;
`endif
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        seen = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done2 && seen == 0) begin
                seen = e;
                check_eq("w2 stim at done", stim2, exp_stim2);
                check_eq("w2 err_cnt", err2, 1);
                check_eq("w2 first_fail", ff2, 2);
                check_eq("w2 fail_seen", fs2, 1);
            end
        end
        check_eq("w2 done edge", seen, exp_done2);
        check_eq("w2 pass", pass2, 0);
        check_eq("w2 busy low", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
